// File: rtl/dram_port_arbiter_if.sv
// Bundles the CPU data port, the Wishbone slave leg and the SRAM port of the data-RAM arbiter.
// The arbiter connects through the slave modport; the environment (CPU, WB master, SRAM) uses master.
interface dram_port_arbiter_if #(
    parameter int RAM_ADDR_WIDTH_WORDS = 8
);
    // CPU data port
    logic                            stb;
    logic [3:0]                      we;
    logic [31:0]                     addr;
    logic [31:0]                     wdata;
    logic [31:0]                     rdata;
    logic                            ack;
    logic                            err;

    // Wishbone slave leg
    logic                            wbs_cyc_i;
    logic                            wbs_stb_i;
    logic                            wbs_we_i;
    logic [3:0]                      wbs_sel_i;
    logic [31:0]                     wbs_adr_i;
    logic [31:0]                     wbs_dat_i;
    logic                            wbs_ack_o;
    logic [31:0]                     wbs_dat_o;

    // Single-port SRAM
    logic                            ram_clk0;
    logic                            ram_csb0;
    logic                            ram_web0;
    logic [3:0]                      ram_wmask0;
    logic [RAM_ADDR_WIDTH_WORDS-1:0] ram_addr0;
    logic [31:0]                     ram_din0;
    logic [31:0]                     ram_dout0;

    modport slave (
        input  stb, we, addr, wdata,
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  ram_dout0,
        output rdata, ack, err, wbs_ack_o, wbs_dat_o,
        output ram_clk0, ram_csb0, ram_web0, ram_wmask0, ram_addr0, ram_din0
    );

    modport master (
        output stb, we, addr, wdata,
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output ram_dout0,
        input  rdata, ack, err, wbs_ack_o, wbs_dat_o,
        input  ram_clk0, ram_csb0, ram_web0, ram_wmask0, ram_addr0, ram_din0
    );
endinterface

// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter sharing the single-port data SRAM between the CPU data port and the WB slave.
// Each granted access runs IDLE -> ACCESS -> RESP; out-of-window requests skip ACCESS.
module dram_port_arbiter #(
    parameter int          RAM_ADDR_WIDTH_WORDS = 8,
    parameter logic [31:0] BASE_ADDR            = 32'h3000_1000
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    dram_port_arbiter_if.slave   bus
);
    localparam int AW = RAM_ADDR_WIDTH_WORDS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          state;
    logic            last_wb;
    logic            gnt_wb;
    logic            oow;
    logic            ram_csb;
    logic            ram_web;
    logic [3:0]      ram_wmask;
    logic [AW-1:0]   ram_addr;
    logic [31:0]     ram_din;
    logic            cpu_ack;
    logic            cpu_err;
    logic            wb_ack;

    logic            cpu_req;
    logic            wb_req;
    logic            pick_wb;
    logic [31:0]     sel_addr;
    logic            sel_write;
    logic [3:0]      sel_mask;
    logic [31:0]     sel_data;
    logic            in_window;
    logic            unused_low_bits;

    assign cpu_req = bus.stb;
    assign wb_req  = bus.wbs_cyc_i & bus.wbs_stb_i;

    // On a tie the requester that was not served last wins.
    assign pick_wb = wb_req & (~cpu_req | ~last_wb);

    assign sel_addr  = pick_wb ? bus.wbs_adr_i : bus.addr;
    assign sel_write = pick_wb ? bus.wbs_we_i  : (|bus.we);
    assign sel_mask  = pick_wb ? bus.wbs_sel_i : bus.we;
    assign sel_data  = pick_wb ? bus.wbs_dat_i : bus.wdata;
    assign in_window = (sel_addr[31:AW+2] == BASE_ADDR[31:AW+2]);

    assign unused_low_bits = ^sel_addr[1:0];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            last_wb   <= 1'b1;
            gnt_wb    <= 1'b0;
            oow       <= 1'b0;
            ram_csb   <= 1'b1;
            ram_web   <= 1'b1;
            ram_wmask <= 4'h0;
            ram_addr  <= '0;
            ram_din   <= '0;
            cpu_ack   <= 1'b0;
            cpu_err   <= 1'b0;
            wb_ack    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req | wb_req) begin
                        gnt_wb <= pick_wb;
                        if (in_window) begin
                            oow       <= 1'b0;
                            ram_csb   <= 1'b0;
                            ram_web   <= ~sel_write;
                            ram_wmask <= sel_write ? sel_mask : 4'h0;
                            ram_addr  <= sel_addr[AW+1:2];
                            if (sel_write) begin
                                ram_din <= sel_data;
                            end
                            state     <= ACCESS;
                        end else begin
                            // No SRAM cycle: respond directly, CPU gets err, WB gets ack with zero data.
                            oow     <= 1'b1;
                            cpu_err <= ~pick_wb;
                            wb_ack  <= pick_wb;
                            state   <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    ram_csb   <= 1'b1;
                    ram_web   <= 1'b1;
                    ram_wmask <= 4'h0;
                    // A WB master that dropped cyc has abandoned the cycle; the SRAM access still completes.
                    if (gnt_wb) begin
                        wb_ack <= bus.wbs_cyc_i;
                    end else begin
                        cpu_ack <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    cpu_ack <= 1'b0;
                    cpu_err <= 1'b0;
                    wb_ack  <= 1'b0;
                    last_wb <= gnt_wb;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ram_clk0   = wb_clk_i;
    assign bus.ram_csb0   = ram_csb;
    assign bus.ram_web0   = ram_web;
    assign bus.ram_wmask0 = ram_wmask;
    assign bus.ram_addr0  = ram_addr;
    assign bus.ram_din0   = ram_din;

    assign bus.ack       = cpu_ack;
    assign bus.err       = cpu_err;
    assign bus.wbs_ack_o = wb_ack;

    // SRAM output is only meaningful in the cycle after the enabled edge, i.e. in RESP.
    assign bus.rdata     = (state == RESP && !gnt_wb && !oow) ? bus.ram_dout0 : 32'h0;
    assign bus.wbs_dat_o = (state == RESP &&  gnt_wb && !oow) ? bus.ram_dout0 : 32'h0;
endmodule
